// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: one-line buffer filled over a line-wide memory
// port, 32-bit word slicing, interrupt/redirect/predictor steering, and a
// circular fetch queue feeding decode through a valid/ready handshake.
module if_prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     LINE_W   = 128,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              intr_valid_i,
  input  logic [XLEN-1:0]   intr_pc_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic [XLEN-1:0]   pc_bp_o,
  input  logic              bp_hit_i,
  input  logic [XLEN-1:0]   bp_target_i,
  output logic              mem_cs_o,
  output logic [XLEN-1:0]   mem_addr_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [XLEN-1:0]   inst_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   pc4_o,
  output logic              bp_hit_o,
  output logic              stall_o
);

  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned WORDS  = LINE_W / 32;
  localparam int unsigned WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned PTR_W  = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0]       fetch_pc;
  logic [XLEN-1:0]       req_addr;
  logic [LINE_W-1:0]     line_data;
  logic [XLEN-1:OFF_W]   line_tag;
  logic                  line_valid;

  logic [XLEN-1:0]       q_inst [FQ_DEPTH];
  logic [XLEN-1:0]       q_pc   [FQ_DEPTH];
  logic                  q_bp   [FQ_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  logic                  flush;
  logic [XLEN-1:0]       flush_pc;
  logic                  tag_hit;
  logic                  q_full;
  logic                  push;
  logic                  pop;
  logic                  start_req;
  logic                  fill;
  logic [WIDX_W-1:0]     widx;
  logic [31:0]           cur_word;

  // Word index within the buffered line
  if (WORDS > 1) begin : g_widx
    assign widx = fetch_pc[OFF_W-1:2];
  end else begin : g_widx1
    assign widx = '0;
  end

  // Steering, hit detection and queue handshake decode
  always_comb begin
    flush     = intr_valid_i | redirect_i;
    flush_pc  = (intr_valid_i ? intr_pc_i : redirect_pc_i) & ~XLEN'(3);
    tag_hit   = line_valid && (line_tag == fetch_pc[XLEN-1:OFF_W]);
    q_full    = (count == CNT_W'(FQ_DEPTH));
    push      = tag_hit && !q_full && !flush;
    pop       = inst_valid_o && inst_ready_i;
    start_req = (state == IDLE) && !tag_hit && !q_full && !flush;
    fill      = (state == REQ) && mem_rvalid_i;
    cur_word  = line_data[32*widx +: 32];
  end

  // Refill FSM next-state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_req)    state_nxt = REQ;
      REQ:     if (mem_rvalid_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Refill FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Fetch PC, request address and line buffer; a redirect never cancels an
  // outstanding request, the fill lands and hit/miss is re-evaluated after
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc   <= RESET_PC;
      req_addr   <= '0;
      line_data  <= '0;
      line_tag   <= '0;
      line_valid <= 1'b0;
    end else begin
      if (flush)       fetch_pc <= flush_pc;
      else if (push)   fetch_pc <= bp_hit_i ? bp_target_i : fetch_pc + XLEN'(4);
      if (start_req)   req_addr <= {fetch_pc[XLEN-1:OFF_W], {OFF_W{1'b0}}};
      if (fill) begin
        line_data  <= mem_rdata_i;
        line_tag   <= req_addr[XLEN-1:OFF_W];
        line_valid <= 1'b1;
      end
    end
  end

  // Queue pointers and occupancy; a flush discards any same-cycle pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage written at the tail
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_inst[wr_ptr] <= cur_word;
      q_pc[wr_ptr]   <= fetch_pc;
      q_bp[wr_ptr]   <= bp_hit_i;
    end
  end

  // Head outputs read as zero while the queue is empty
  always_comb begin
    inst_valid_o = (count != '0);
    inst_o       = inst_valid_o ? q_inst[rd_ptr] : '0;
    pc_o         = inst_valid_o ? q_pc[rd_ptr] : '0;
    pc4_o        = inst_valid_o ? q_pc[rd_ptr] + XLEN'(4) : '0;
    bp_hit_o     = inst_valid_o ? q_bp[rd_ptr] : 1'b0;
    mem_cs_o     = (state == REQ);
    mem_addr_o   = req_addr;
    pc_bp_o      = fetch_pc;
    stall_o      = !inst_valid_o && (state == REQ);
  end

endmodule
